hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding block for the 5-stage pipeline (F/D/E/M/W). It adds three things to combinational forwarding and load-use/branch stalling:
- register address width as a parameter;
- an internal multi-cycle multiply/divide (MDU) busy scoreboard that replaces the external done signal;
- optional stall-cycle performance counters.

It sits beside the datapath, takes stage register addresses and control bits, and drives the forwarding muxes and the F/D stall and E flush controls.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/mdu_busy_counter.sv | 39 +++
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding mux selects and perf counter width.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/mdu_busy_counter.sv
// Multi-cycle MDU busy tracker: IDLE when cnt is zero, BUSY otherwise.
module mdu_busy_counter
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    // A start while already busy simply restarts the countdown.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(MDU_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding, load-use/branch/MDU stall detection for the 5-stage pipeline.
// Optional stall performance counters enabled with HAZARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned RW      = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RW-1:0]     rs_d,
    input  logic [RW-1:0]     rt_d,
    input  logic [RW-1:0]     rs_e,
    input  logic [RW-1:0]     rt_e,
    input  logic [RW-1:0]     writereg_e,
    input  logic [RW-1:0]     writereg_m,
    input  logic [RW-1:0]     writereg_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memtoreg_e,
    input  logic              memtoreg_m,
    input  logic              branch_d,
    input  logic              mdu_start_e,
    input  logic              mdu_start_d,
    input  logic              hilo_read_d,
    output logic              forwarda_d,
    output logic              forwardb_d,
    output logic [1:0]        forwarda_e,
    output logic [1:0]        forwardb_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_lw_cnt,
    output logic [PERF_W-1:0] perf_mdu_cnt
);

    logic lwstall, branchstall, mdustall;

    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                           input logic [RW-1:0] wr_m, input logic rw_m,
                                           input logic [RW-1:0] wr_w, input logic rw_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (rw_m && (src == wr_m)) begin
                sel = FWD_MEM;
            end else if (rw_w && (src == wr_w)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    assign forwarda_d = (rs_d != '0) && (rs_d == writereg_m) && regwrite_m;
    assign forwardb_d = (rt_d != '0) && (rt_d == writereg_m) && regwrite_m;
    assign forwarda_e = fwd_sel(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
    assign forwardb_e = fwd_sel(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);

    mdu_busy_counter #(
        .MDU_LAT (MDU_LAT),
        .CW      (CW)
    ) u_mdu_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (mdu_start_e),
        .busy  (mdu_busy)
    );

    assign lwstall     = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    assign branchstall = branch_d &&
                         ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                          (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));
    // A start in E already blocks dependents before busy registers.
    assign mdustall    = (mdu_busy || mdu_start_e) && (hilo_read_d || mdu_start_d);

    assign stall_d = lwstall || branchstall || mdustall;
    assign stall_f = stall_d;
    assign flush_e = stall_d;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_lw_q, perf_mdu_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_lw_q    <= '0;
            perf_mdu_q   <= '0;
        end else begin
            if (stall_d)  perf_stall_q <= perf_stall_q + PERF_W'(1);
            if (lwstall)  perf_lw_q    <= perf_lw_q + PERF_W'(1);
            if (mdustall) perf_mdu_q   <= perf_mdu_q + PERF_W'(1);
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_lw_cnt    = perf_lw_q;
    assign perf_mdu_cnt   = perf_mdu_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_lw_cnt    = '0;
    assign perf_mdu_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, MDU sequences, randomized model check.
module tb_hazard_scoreboard;

    localparam int RW  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, branch_d;
    logic mdu_start_e, mdu_start_d, hilo_read_d;
    logic forwarda_d, forwardb_d, stall_f, stall_d, flush_e, mdu_busy;
    logic [1:0] forwarda_e, forwardb_e;
    logic [31:0] perf_stall_cnt, perf_lw_cnt, perf_mdu_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.RW(RW), .MDU_LAT(LAT), .CW(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .rs_e           (rs_e),
        .rt_e           (rt_e),
        .writereg_e     (writereg_e),
        .writereg_m     (writereg_m),
        .writereg_w     (writereg_w),
        .regwrite_e     (regwrite_e),
        .regwrite_m     (regwrite_m),
        .regwrite_w     (regwrite_w),
        .memtoreg_e     (memtoreg_e),
        .memtoreg_m     (memtoreg_m),
        .branch_d       (branch_d),
        .mdu_start_e    (mdu_start_e),
        .mdu_start_d    (mdu_start_d),
        .hilo_read_d    (hilo_read_d),
        .forwarda_d     (forwarda_d),
        .forwardb_d     (forwardb_d),
        .forwarda_e     (forwarda_e),
        .forwardb_e     (forwardb_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_e        (flush_e),
        .mdu_busy       (mdu_busy),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_lw_cnt    (perf_lw_cnt),
        .perf_mdu_cnt   (perf_mdu_cnt)
    );

    typedef struct {
        logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic          rw_e, rw_m, rw_w, mr_e, mr_m, br_d;
        logic          x_fad, x_fbd;
        logic [1:0]    x_fae, x_fbe;
        logic          x_stall;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        writereg_e = '0; writereg_m = '0; writereg_w = '0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0; branch_d = 0;
        mdu_start_e = 0; mdu_start_d = 0; hilo_read_d = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Reference forwarding rule for one E-stage operand.
    function automatic logic [1:0] ref_fwd(input int src, input int wm, input int rwm,
                                           input int ww, input int rww);
        if (src == 0) return 2'd0;
        if (rwm != 0 && src == wm) return 2'd2;
        if (rww != 0 && src == ww) return 2'd1;
        return 2'd0;
    endfunction

    int   last_start;
    int   acc_stall, acc_lw, acc_mdu;
    logic exp_busy, exp_lw, exp_br, exp_md, exp_st;
    logic rnd_reset;

    initial begin
        vecs[0]  = '{0,0,3,0,0,3,3, 0,1,1,0,0,0, 0,0,2'd2,2'd0,0};
        vecs[1]  = '{0,0,3,0,0,3,3, 0,0,1,0,0,0, 0,0,2'd1,2'd0,0};
        vecs[2]  = '{0,0,0,0,0,3,3, 0,1,1,0,0,0, 0,0,2'd0,2'd0,0};
        vecs[3]  = '{7,0,0,7,0,0,0, 0,0,0,1,0,0, 0,0,2'd0,2'd0,1};
        vecs[4]  = '{7,0,0,8,0,0,0, 0,0,0,1,0,0, 0,0,2'd0,2'd0,0};
        vecs[5]  = '{0,4,0,0,0,4,0, 0,0,0,0,1,1, 0,0,2'd0,2'd0,1};
        vecs[6]  = '{0,4,0,0,4,0,0, 1,0,0,0,0,1, 0,0,2'd0,2'd0,1};
        vecs[7]  = '{5,5,5,6,0,5,6, 0,1,1,0,0,0, 1,1,2'd2,2'd1,0};
        vecs[8]  = '{0,0,0,0,0,0,0, 0,1,1,0,0,0, 0,0,2'd0,2'd0,0};
        vecs[9]  = '{1,2,0,0,3,4,0, 1,0,0,0,1,1, 0,0,2'd0,2'd0,0};
        vecs[10] = '{1,9,0,9,0,0,0, 0,0,0,1,0,0, 0,0,2'd0,2'd0,1};

        clear_inputs();
        reset = 1'b1;
        #2;
        check("reset_busy", {31'd0, mdu_busy}, 32'd0);
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
        check("reset_perf_lw", perf_lw_cnt, 32'd0);
        check("reset_perf_mdu", perf_mdu_cnt, 32'd0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            next_cycle();
            rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
            writereg_e = vecs[i].wr_e; writereg_m = vecs[i].wr_m; writereg_w = vecs[i].wr_w;
            regwrite_e = vecs[i].rw_e; regwrite_m = vecs[i].rw_m; regwrite_w = vecs[i].rw_w;
            memtoreg_e = vecs[i].mr_e; memtoreg_m = vecs[i].mr_m; branch_d = vecs[i].br_d;
            #2;
            check($sformatf("vec%0d_fad", i), {31'd0, forwarda_d}, {31'd0, vecs[i].x_fad});
            check($sformatf("vec%0d_fbd", i), {31'd0, forwardb_d}, {31'd0, vecs[i].x_fbd});
            check($sformatf("vec%0d_fae", i), {30'd0, forwarda_e}, {30'd0, vecs[i].x_fae});
            check($sformatf("vec%0d_fbe", i), {30'd0, forwardb_e}, {30'd0, vecs[i].x_fbe});
            check($sformatf("vec%0d_stall_d", i), {31'd0, stall_d}, {31'd0, vecs[i].x_stall});
            check($sformatf("vec%0d_stall_f", i), {31'd0, stall_f}, {31'd0, vecs[i].x_stall});
            check($sformatf("vec%0d_flush_e", i), {31'd0, flush_e}, {31'd0, vecs[i].x_stall});
        end

        // MDU start in cycle 0 with HI/LO read held, then one load-use stall.
        do_reset();
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k > 0) next_cycle();
            mdu_start_e = (k == 0);
            hilo_read_d = 1'b1;
            #2;
            check($sformatf("mdu_c%0d_stall", k), {31'd0, stall_d}, {31'd0, (k <= LAT)});
            check($sformatf("mdu_c%0d_busy", k), {31'd0, mdu_busy},
                  {31'd0, (k >= 1 && k <= LAT)});
        end
        next_cycle();
        clear_inputs();
        memtoreg_e = 1; rt_e = 7; rs_d = 7;
        #2;
        check("lw_after_mdu_stall", {31'd0, stall_d}, 32'd1);
        next_cycle();
        clear_inputs();
        #2;
`ifdef HAZARD_PERF_EN
        check("perf_stall", perf_stall_cnt, 32'd6);
        check("perf_mdu", perf_mdu_cnt, 32'd5);
        check("perf_lw", perf_lw_cnt, 32'd1);
`else
        check("perf_stall", perf_stall_cnt, 32'd0);
        check("perf_mdu", perf_mdu_cnt, 32'd0);
        check("perf_lw", perf_lw_cnt, 32'd0);
`endif

        // Reset in the middle of a busy window.
        next_cycle();
        mdu_start_e = 1;
        next_cycle();
        mdu_start_e = 0;
        #2;
        check("mid_busy_before_rst", {31'd0, mdu_busy}, 32'd1);
        next_cycle();
        reset = 1'b1;
        #1;
        check("mid_busy_async_rst", {31'd0, mdu_busy}, 32'd0);
        next_cycle();
        reset = 1'b0;
        hilo_read_d = 1;
        #2;
        check("post_rst_hilo_stall", {31'd0, stall_d}, 32'd0);
        check("post_rst_busy", {31'd0, mdu_busy}, 32'd0);

        // Randomized run against a cycle-indexed model.
        do_reset();
        last_start = -1000;
        acc_stall = 0; acc_lw = 0; acc_mdu = 0;
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            rnd_reset   = ($urandom_range(39) == 0);
            reset       = rnd_reset;
            rs_d        = RW'($urandom_range(3));
            rt_d        = RW'($urandom_range(3));
            rs_e        = RW'($urandom_range(3));
            rt_e        = RW'($urandom_range(3));
            writereg_e  = RW'($urandom_range(3));
            writereg_m  = RW'($urandom_range(3));
            writereg_w  = RW'($urandom_range(3));
            regwrite_e  = 1'($urandom_range(1));
            regwrite_m  = 1'($urandom_range(1));
            regwrite_w  = 1'($urandom_range(1));
            memtoreg_e  = ($urandom_range(3) == 0);
            memtoreg_m  = ($urandom_range(3) == 0);
            branch_d    = ($urandom_range(3) == 0);
            mdu_start_e = ($urandom_range(5) == 0);
            mdu_start_d = ($urandom_range(3) == 0);
            hilo_read_d = ($urandom_range(2) == 0);
            #2;
            if (rnd_reset) begin
                exp_busy   = 1'b0;
                last_start = -1000;
                acc_stall = 0; acc_lw = 0; acc_mdu = 0;
            end else begin
                exp_busy = (c - last_start >= 1) && (c - last_start <= LAT);
            end
            exp_lw = memtoreg_e && (int'(rt_e) == int'(rs_d) || int'(rt_e) == int'(rt_d));
            exp_br = branch_d &&
                     ((regwrite_e && (int'(writereg_e) == int'(rs_d) ||
                                      int'(writereg_e) == int'(rt_d))) ||
                      (memtoreg_m && (int'(writereg_m) == int'(rs_d) ||
                                      int'(writereg_m) == int'(rt_d))));
            exp_md = (exp_busy || mdu_start_e) && (hilo_read_d || mdu_start_d);
            exp_st = exp_lw || exp_br || exp_md;

            check("rnd_fad", {31'd0, forwarda_d},
                  {31'd0, (rs_d != 0 && rs_d == writereg_m && regwrite_m)});
            check("rnd_fbd", {31'd0, forwardb_d},
                  {31'd0, (rt_d != 0 && rt_d == writereg_m && regwrite_m)});
            check("rnd_fae", {30'd0, forwarda_e}, {30'd0, ref_fwd(int'(rs_e), int'(writereg_m),
                  int'(regwrite_m), int'(writereg_w), int'(regwrite_w))});
            check("rnd_fbe", {30'd0, forwardb_e}, {30'd0, ref_fwd(int'(rt_e), int'(writereg_m),
                  int'(regwrite_m), int'(writereg_w), int'(regwrite_w))});
            check("rnd_busy", {31'd0, mdu_busy}, {31'd0, exp_busy});
            check("rnd_stall_d", {31'd0, stall_d}, {31'd0, exp_st});
            check("rnd_stall_f", {31'd0, stall_f}, {31'd0, exp_st});
            check("rnd_flush_e", {31'd0, flush_e}, {31'd0, exp_st});
`ifdef HAZARD_PERF_EN
            check("rnd_perf_stall", perf_stall_cnt, 32'(acc_stall));
            check("rnd_perf_lw", perf_lw_cnt, 32'(acc_lw));
            check("rnd_perf_mdu", perf_mdu_cnt, 32'(acc_mdu));
`else
            check("rnd_perf_stall", perf_stall_cnt, 32'd0);
            check("rnd_perf_lw", perf_lw_cnt, 32'd0);
            check("rnd_perf_mdu", perf_mdu_cnt, 32'd0);
`endif
            if (!rnd_reset) begin
                acc_stall += int'(exp_st);
                acc_lw    += int'(exp_lw);
                acc_mdu   += int'(exp_md);
                if (mdu_start_e) last_start = c;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
